// File: rtl/clkgen_sup_pkg.sv
// clkgen_sup_pkg
//   Shared definitions for the clock-generator supervisor:
//   - sup_state_e : FSM state encoding, also driven on the debug 'state' port
//   - DEF_*       : default values for the supervisor parameters
//   - max3        : helper used to size the shared timer
package clkgen_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } sup_state_e;

  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_HB_WINDOW     = 256;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clkgen_supervisor_if.sv
// clkgen_supervisor_if
//   Groups the supervisor's status and MMCM-facing signals.
//   Signalling: every signal is a level, no valid/ready handshake. Inputs
//   (locked, dot_heartbeat) may change at any time and are synchronized inside
//   the supervisor; outputs are registered and change only on clk_in50mhz.
//   Modports:
//     master : the supervisor (drives resets and status, reads locked/heartbeat)
//     slave  : the clock generator / system side
//   Parameter RW : width of retry_count, $clog2(MAX_RETRIES+1).
interface clkgen_supervisor_if #(
  parameter int RW = 3
);
  logic          locked;
  logic          dot_heartbeat;
  logic          clkgen_reset;
  logic          sys_reset;
  logic          ready;
  logic          fail;
  logic          lock_lost;
  logic [RW-1:0] retry_count;
  logic [2:0]    state;

  modport master (
    input  locked, dot_heartbeat,
    output clkgen_reset, sys_reset, ready, fail, lock_lost, retry_count, state
  );

  modport slave (
    output locked, dot_heartbeat,
    input  clkgen_reset, sys_reset, ready, fail, lock_lost, retry_count, state
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit
//   Single-bit flop-chain synchronizer with synchronous active-low reset.
//   Ports: clk, rst_n (sync, active low), d (async input), q (synchronized).
//   Parameter STAGES (>= 2): number of flops in the chain.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clkgen_supervisor.sv
// clkgen_supervisor
//   Sequences the MMCM reset of the dot4x/col4x clock generator: pulses
//   clkgen_reset, waits for lock with a timeout and bounded retries, demands
//   SETTLE_CYCLES of continuous lock before releasing sys_reset, and
//   re-sequences on loss of lock in RUN.
//   Optional macro CLKGEN_HEARTBEAT_EN: also watch dot_heartbeat toggles from
//   the dot4x domain; a gap of HB_WINDOW cycles in RUN counts as lock loss.
//   Ports:
//     clk_in50mhz : board clock, sole clock
//     reset_n     : synchronous active-low reset
//     sup         : clkgen_supervisor_if.master (locked, dot_heartbeat in;
//                   clkgen_reset, sys_reset, ready, fail, lock_lost,
//                   retry_count, state out)
module clkgen_supervisor
  import clkgen_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int HB_WINDOW     = DEF_HB_WINDOW
) (
  input  logic            clk_in50mhz,
  input  logic            reset_n,
  clkgen_supervisor_if.master sup
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(max3(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES) + 1);

  sup_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          attempt_fail;
  logic          locked_s;
  logic          hb_timeout;
  logic          clkgen_reset_q, sys_reset_q, ready_q, fail_q;

  cdc_sync_bit #(.STAGES(2)) u_lock_sync (
    .clk   (clk_in50mhz),
    .rst_n (reset_n),
    .d     (sup.locked),
    .q     (locked_s)
  );

`ifdef CLKGEN_HEARTBEAT_EN
  localparam int HW = $clog2(HB_WINDOW);

  logic          hb_s, hb_prev, hb_edge, run_entry;
  logic [HW-1:0] hb_cnt;

  cdc_sync_bit #(.STAGES(3)) u_hb_sync (
    .clk   (clk_in50mhz),
    .rst_n (reset_n),
    .d     (sup.dot_heartbeat),
    .q     (hb_s)
  );

  assign hb_edge   = hb_s ^ hb_prev;
  assign run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);

  // Counter only advances in RUN and saturates at the window limit.
  always_ff @(posedge clk_in50mhz) begin
    if (!reset_n) begin
      hb_prev <= 1'b0;
      hb_cnt  <= '0;
    end else begin
      hb_prev <= hb_s;
      if (hb_edge || run_entry)
        hb_cnt <= '0;
      else if (state_q == ST_RUN && hb_cnt != HW'(HB_WINDOW - 1))
        hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign hb_timeout = (state_q == ST_RUN) && (hb_cnt == HW'(HB_WINDOW - 1));
`else
  logic unused_hb;
  assign unused_hb  = sup.dot_heartbeat;
  assign hb_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    lost_d       = lost_q;
    attempt_fail = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (timer_q == TW'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (locked_s) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        // A drop in lock aborts even on the final settle cycle.
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s || hb_timeout) begin
          lost_d  = 1'b1;
          state_d = ST_RESET;
          timer_d = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET;
        timer_d = '0;
      end
    endcase

    if (attempt_fail) begin
      timer_d = '0;
      if (retry_q == RW'(MAX_RETRIES)) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_RESET;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with 'state'.
  always_ff @(posedge clk_in50mhz) begin
    if (!reset_n) begin
      state_q        <= ST_RESET;
      timer_q        <= '0;
      retry_q        <= '0;
      lost_q         <= 1'b0;
      clkgen_reset_q <= 1'b1;
      sys_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      lost_q         <= lost_d;
      clkgen_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      sys_reset_q    <= (state_d != ST_RUN);
      ready_q        <= (state_d == ST_RUN);
      fail_q         <= (state_d == ST_FAIL);
    end
  end

  assign sup.clkgen_reset = clkgen_reset_q;
  assign sup.sys_reset    = sys_reset_q;
  assign sup.ready        = ready_q;
  assign sup.fail         = fail_q;
  assign sup.lock_lost    = lost_q;
  assign sup.retry_count  = retry_q;
  assign sup.state        = state_q;

endmodule

// File: tb/tb_clkgen_supervisor.sv
// tb_clkgen_supervisor
//   Directed bench for clkgen_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=32,
//   SETTLE_CYCLES=8, MAX_RETRIES=2, HB_WINDOW=16. Stimulus pushes expected
//   output snapshots tagged with the cycle they are due; a negedge monitor
//   compares them against the DUT. The heartbeat scenario is only exercised
//   when CLKGEN_HEARTBEAT_EN is defined.
module tb_clkgen_supervisor;
  import clkgen_sup_pkg::*;

  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clkgen_supervisor_if #(.RW(2)) sif ();

  clkgen_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .SETTLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .HB_WINDOW     (16)
  ) dut (
    .clk_in50mhz (clk),
    .reset_n     (reset_n),
    .sup         (sif.master)
  );

  // ---------------- heartbeat toggler ----------------
  logic hb_tgl  = 1'b0;
  logic hb_run  = 1'b1;
  int   hb_last = 0;

  assign sif.dot_heartbeat = hb_tgl;

  always @(negedge clk) begin
    if (hb_run && (cyc % 8 == 0)) begin
      hb_tgl  = ~hb_tgl;
      hb_last = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // {state, retry_count, lock_lost, fail, ready, sys_reset, clkgen_reset}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [1:0] rc,
                                      input logic lost);
    logic run, fl;
    run = (st == 3'd3);
    fl  = (st == 3'd4);
    return {st, rc, lost, fl, run, ~run, (st == 3'd0) || fl};
  endfunction

  task automatic expect_at(input int at, input string nm, input logic [2:0] st,
                           input logic [1:0] rc, input logic lost);
    exp_q.push_back(mk(st, rc, lost));
    due_q.push_back(at);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] act;
    int i;
    act = {sif.state, sif.retry_count, sif.lock_lost, sif.fail, sif.ready,
           sif.sys_reset, sif.clkgen_reset};
    i = 0;
    while (i < exp_q.size()) begin
      if (due_q[i] <= cyc) begin
        checks++;
        if (due_q[i] < cyc) begin
          errors++;
          $display("FAIL %s: check due at cycle %0d missed (now %0d)", name_q[i], due_q[i], cyc);
        end else if (act !== exp_q[i]) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %b required %b (st,rc,lost,fail,rdy,sysrst,mmcmrst)",
                   name_q[i], cyc, act, exp_q[i]);
        end
        exp_q.delete(i);
        due_q.delete(i);
        name_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int at);
    while (cyc < at) @(negedge clk);
  endtask

  // Called at a negedge; leaves reset_n high at a negedge.
  task automatic apply_reset(input string nm);
    reset_n = 1'b0;
    expect_at(cyc + 1, nm, ST_RESET, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, l0, t;
    sif.locked = 1'b0;
    @(negedge clk);

    // Clean lock: locked rises 10 cycles after release.
    apply_reset("reset_values");
    c0 = cyc;
    expect_at(c0 + 3,  "clean_rst_held",  ST_RESET,     2'd0, 1'b0);
    expect_at(c0 + 4,  "clean_rst_rel",   ST_WAIT_LOCK, 2'd0, 1'b0);
    expect_at(c0 + 12, "clean_wait_end",  ST_WAIT_LOCK, 2'd0, 1'b0);
    expect_at(c0 + 13, "clean_settle",    ST_SETTLE,    2'd0, 1'b0);
    expect_at(c0 + 20, "clean_settle_end", ST_SETTLE,   2'd0, 1'b0);
    expect_at(c0 + 21, "clean_run",       ST_RUN,       2'd0, 1'b0);
    wait_until(c0 + 10);
    sif.locked = 1'b1;
    wait_until(c0 + 25);

    // Loss in RUN, then re-lock.
    c0 = cyc;
    sif.locked = 1'b0;
    expect_at(c0 + 2,  "loss_still_run",  ST_RUN,       2'd0, 1'b0);
    expect_at(c0 + 3,  "loss_reset",      ST_RESET,     2'd0, 1'b1);
    expect_at(c0 + 7,  "loss_wait",       ST_WAIT_LOCK, 2'd0, 1'b1);
    expect_at(c0 + 13, "relock_settle",   ST_SETTLE,    2'd0, 1'b1);
    expect_at(c0 + 21, "relock_run",      ST_RUN,       2'd0, 1'b1);
    wait_until(c0 + 10);
    sif.locked = 1'b1;
    wait_until(c0 + 25);

    // reset_n asserted in the middle of WAIT_LOCK clears lock_lost.
    c0 = cyc;
    sif.locked = 1'b0;
    expect_at(c0 + 3, "midwait_reset_st", ST_RESET,     2'd0, 1'b1);
    expect_at(c0 + 7, "midwait_wait",     ST_WAIT_LOCK, 2'd0, 1'b1);
    wait_until(c0 + 10);
    apply_reset("midwait_reset_n");

    // Glitch seen by the FSM at SETTLE cycle 5.
    c0 = cyc;
    l0 = c0 + 10;
    expect_at(l0 + 7,  "glitch_settle",   ST_SETTLE,    2'd0, 1'b0);
    expect_at(l0 + 8,  "glitch_fail",     ST_RESET,     2'd1, 1'b0);
    expect_at(l0 + 12, "glitch_wait",     ST_WAIT_LOCK, 2'd1, 1'b0);
    expect_at(l0 + 13, "glitch_settle2",  ST_SETTLE,    2'd1, 1'b0);
    expect_at(l0 + 20, "glitch_settle2e", ST_SETTLE,    2'd1, 1'b0);
    expect_at(l0 + 21, "glitch_run_clr",  ST_RUN,       2'd0, 1'b0);
    expect_at(l0 + 49, "run_holds",       ST_RUN,       2'd0, 1'b0);
    wait_until(l0);
    sif.locked = 1'b1;
    wait_until(l0 + 5);
    sif.locked = 1'b0;
    wait_until(l0 + 6);
    sif.locked = 1'b1;
    wait_until(l0 + 50);

`ifdef CLKGEN_HEARTBEAT_EN
    // Heartbeat stops in RUN: behaves like lock loss.
    while (cyc % 8 != 3) @(negedge clk);
    hb_run = 1'b0;
    t = hb_last;
    expect_at(t + 19, "hb_last_run", ST_RUN,   2'd0, 1'b0);
    expect_at(t + 20, "hb_timeout",  ST_RESET, 2'd0, 1'b1);
    wait_until(t + 24);
    hb_run = 1'b1;
    wait_until(t + 40);
`else
    t = 0;
`endif

    // Timeout and lock arrive on the same WAIT_LOCK cycle: lock wins.
    sif.locked = 1'b0;
    apply_reset("tie_reset");
    c0 = cyc;
    expect_at(c0 + 35, "tie_wait_last", ST_WAIT_LOCK, 2'd0, 1'b0);
    expect_at(c0 + 36, "tie_lock_wins", ST_SETTLE,    2'd0, 1'b0);
    expect_at(c0 + 44, "tie_run",       ST_RUN,       2'd0, 1'b0);
    wait_until(c0 + 33);
    sif.locked = 1'b1;
    wait_until(c0 + 46);

    // No lock ever: two retries, then terminal FAIL.
    sif.locked = 1'b0;
    apply_reset("nolock_reset");
    c0 = cyc;
    expect_at(c0 + 3,   "nl_rst",        ST_RESET,     2'd0, 1'b0);
    expect_at(c0 + 35,  "nl_wait1_last", ST_WAIT_LOCK, 2'd0, 1'b0);
    expect_at(c0 + 36,  "nl_retry1",     ST_RESET,     2'd1, 1'b0);
    expect_at(c0 + 39,  "nl_retry1_rst", ST_RESET,     2'd1, 1'b0);
    expect_at(c0 + 40,  "nl_wait2",      ST_WAIT_LOCK, 2'd1, 1'b0);
    expect_at(c0 + 71,  "nl_wait2_last", ST_WAIT_LOCK, 2'd1, 1'b0);
    expect_at(c0 + 72,  "nl_retry2",     ST_RESET,     2'd2, 1'b0);
    expect_at(c0 + 76,  "nl_wait3",      ST_WAIT_LOCK, 2'd2, 1'b0);
    expect_at(c0 + 107, "nl_wait3_last", ST_WAIT_LOCK, 2'd2, 1'b0);
    expect_at(c0 + 108, "nl_fail",       ST_FAIL,      2'd2, 1'b0);
    expect_at(c0 + 150, "nl_fail_holds", ST_FAIL,      2'd2, 1'b0);
    wait_until(c0 + 152);
    apply_reset("fail_exit_reset");
    repeat (4) @(negedge clk);

    // ---------------- final report ----------------
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: check due at cycle %0d never evaluated", name_q[0], due_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
